// File: rtl/fetch_pc_predict.sv
// Fetch PC register with a direct-mapped BTB and 2-bit saturating counters.
// Produces a same-cycle prediction for fetch_pc and accepts resolved-branch updates.
module fetch_pc_predict #(
  parameter int                    WordSize = 32,
  parameter int                    Entries  = 16,
  parameter logic [WordSize-1:0]   ResetPC  = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                stall,
  input  logic                redirect,
  input  logic [WordSize-1:0] redirect_pc,
  input  logic                upd_valid,
  input  logic [WordSize-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [WordSize-1:0] upd_target,
  output logic [WordSize-1:0] fetch_pc,
  output logic                pred_taken,
  output logic [WordSize-1:0] pred_pc
);

  localparam int IW = $clog2(Entries);
  localparam int TW = WordSize - IW - 2;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  logic [Entries-1:0]  valid_q;
  logic [TW-1:0]       tag_q    [Entries];
  logic [WordSize-1:0] target_q [Entries];
  logic [1:0]          ctr_q    [Entries];

  logic [IW-1:0]       lk_idx;
  logic [TW-1:0]       lk_tag;
  logic                lk_hit;
  logic [WordSize-1:0] pc_plus4;

  logic [IW-1:0]       up_idx;
  logic [TW-1:0]       up_tag;
  logic                up_hit;

  // Byte-offset bits carry no information for word-aligned instructions.
  logic                unused_lsbs;
  assign unused_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  // Lookup stage: zero-cycle prediction from the registered fetch PC.
  assign lk_idx     = fetch_pc[IW+1:2];
  assign lk_tag     = fetch_pc[WordSize-1:IW+2];
  assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pc_plus4   = fetch_pc + WordSize'(4);
  assign pred_taken = lk_hit && ctr_q[lk_idx][1];
  assign pred_pc    = pred_taken ? target_q[lk_idx] : pc_plus4;

  assign up_idx = upd_pc[IW+1:2];
  assign up_tag = upd_pc[WordSize-1:IW+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Fetch PC register: redirect outranks stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= ResetPC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
    end else if (!stall) begin
      fetch_pc <= pred_pc;
    end
  end

  // BTB update stage: new contents become visible to lookup on the next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'd0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          ctr_q[up_idx]    <= ctr_inc(ctr_q[up_idx]);
          target_q[up_idx] <= upd_target;
        end else begin
          ctr_q[up_idx]    <= ctr_dec(ctr_q[up_idx]);
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Scoreboard bench for fetch_pc_predict: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_fetch_pc_predict;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_pc;

  fetch_pc_predict #(
    .WordSize (32),
    .Entries  (16),
    .ResetPC  (32'h100)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .fetch_pc    (fetch_pc),
    .pred_taken  (pred_taken),
    .pred_pc     (pred_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ppc;
  } exp_t;

  exp_t exp_q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  // Monitor: compare each pending expectation against what the DUT presents.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_total++;
      if (fetch_pc === e.pc) n_passed++;
      else $display("FAIL %s.fetch_pc got %h expected %h", e.name, fetch_pc, e.pc);
      n_total++;
      if (pred_taken === e.pt) n_passed++;
      else $display("FAIL %s.pred_taken got %b expected %b", e.name, pred_taken, e.pt);
      n_total++;
      if (pred_pc === e.ppc) n_passed++;
      else $display("FAIL %s.pred_pc got %h expected %h", e.name, pred_pc, e.ppc);
    end
  end

  // Drive one cycle of inputs, record the outputs expected during that cycle, advance.
  task automatic cyc(input string name, input logic st, input logic rd, input logic [31:0] rpc,
                     input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                     input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ppc);
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    upd_valid   = uv;
    upd_pc      = upc;
    upd_taken   = ut;
    upd_target  = utg;
    e.name = name;
    e.pc   = e_pc;
    e.pt   = e_pt;
    e.ppc  = e_ppc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    @(posedge clk);
    #1;
    cyc("rst_hold",   0,0,0,            0,0,0,0,                  32'h100,0,32'h104);
    rstn = 1'b1;

    // Sequential fetch after reset
    cyc("seq0",       0,0,0,            0,0,0,0,                  32'h100,0,32'h104);
    cyc("seq1",       0,0,0,            0,0,0,0,                  32'h104,0,32'h108);
    cyc("seq2",       0,0,0,            0,0,0,0,                  32'h108,0,32'h10C);
    // Allocate 0x108 -> 0x200, then replay the path
    cyc("alloc",      1,0,0,            1,32'h108,1,32'h200,      32'h10C,0,32'h110);
    cyc("redir100",   0,1,32'h100,      0,0,0,0,                  32'h10C,0,32'h110);
    cyc("rp100",      0,0,0,            0,0,0,0,                  32'h100,0,32'h104);
    cyc("rp104",      0,0,0,            0,0,0,0,                  32'h104,0,32'h108);
    cyc("rp108_hit",  0,0,0,            0,0,0,0,                  32'h108,1,32'h200);
    cyc("rp200",      0,0,0,            0,0,0,0,                  32'h200,0,32'h204);
    // Counter decrement and saturation at 0
    cyc("nt1",        1,0,0,            1,32'h108,0,0,            32'h204,0,32'h208);
    cyc("redir108",   1,1,32'h108,      0,0,0,0,                  32'h204,0,32'h208);
    cyc("ctr1",       1,0,0,            0,0,0,0,                  32'h108,0,32'h10C);
    cyc("nt2",        1,0,0,            1,32'h108,0,0,            32'h108,0,32'h10C);
    cyc("nt3",        1,0,0,            1,32'h108,0,0,            32'h108,0,32'h10C);
    cyc("tk_from0",   1,0,0,            1,32'h108,1,32'h200,      32'h108,0,32'h10C);
    cyc("ctr1b",      1,0,0,            0,0,0,0,                  32'h108,0,32'h10C);
    // Counter increment and saturation at 3
    cyc("tk2",        1,0,0,            1,32'h108,1,32'h200,      32'h108,0,32'h10C);
    cyc("tk3",        1,0,0,            1,32'h108,1,32'h200,      32'h108,1,32'h200);
    cyc("tk_sat",     1,0,0,            1,32'h108,1,32'h200,      32'h108,1,32'h200);
    cyc("nt_from3",   1,0,0,            1,32'h108,0,0,            32'h108,1,32'h200);
    cyc("ctr2",       1,0,0,            1,32'h108,0,0,            32'h108,1,32'h200);
    cyc("ctr1c",      1,0,0,            0,0,0,0,                  32'h108,0,32'h10C);
    // Aliasing: 0x148 shares index 2 with 0x108
    cyc("alias_upd",  1,0,0,            1,32'h148,1,32'h500,      32'h108,0,32'h10C);
    cyc("alias_miss", 1,1,32'h148,      0,0,0,0,                  32'h108,0,32'h10C);
    cyc("alias_hit",  1,0,0,            0,0,0,0,                  32'h148,1,32'h500);
    // Redirect overrides stall
    cyc("st_redir",   1,1,32'h400,      0,0,0,0,                  32'h148,1,32'h500);
    cyc("hold400a",   1,0,0,            0,0,0,0,                  32'h400,0,32'h404);
    cyc("hold400b",   1,0,0,            0,0,0,0,                  32'h400,0,32'h404);
    // Same-cycle update and lookup
    cyc("realloc",    1,0,0,            1,32'h108,1,32'h200,      32'h400,0,32'h404);
    cyc("redir108b",  0,0,0,            0,0,0,0,                  32'h400,0,32'h404);
    cyc("to108",      1,1,32'h108,      0,0,0,0,                  32'h404,0,32'h408);
    cyc("same_cyc",   0,0,0,            1,32'h108,1,32'h300,      32'h108,1,32'h200);
    cyc("back108",    0,1,32'h108,      0,0,0,0,                  32'h200,0,32'h204);
    cyc("new_tgt",    1,0,0,            0,0,0,0,                  32'h108,1,32'h300);
    // Miss with not-taken leaves the occupant alone
    cyc("miss_nt",    1,0,0,            1,32'h148,0,0,            32'h108,1,32'h300);
    cyc("kept",       1,0,0,            0,0,0,0,                  32'h108,1,32'h300);
    // PC+4 wraparound
    cyc("redir_top",  1,1,32'hFFFFFFFC, 0,0,0,0,                  32'h108,1,32'h300);
    cyc("wrap",       0,0,0,            0,0,0,0,                  32'hFFFFFFFC,0,32'h0);
    cyc("after_wrap", 0,0,0,            0,0,0,0,                  32'h0,0,32'h4);
    // Mid-operation reset clears PC and BTB
    rstn = 1'b0;
    cyc("mid_rst",    0,0,0,            0,0,0,0,                  32'h100,0,32'h104);
    rstn = 1'b1;
    cyc("post_rst",   0,1,32'h108,      0,0,0,0,                  32'h100,0,32'h104);
    cyc("btb_clear",  1,0,0,            0,0,0,0,                  32'h108,0,32'h10C);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_pc_predict.md
Name: fetch_pc_predict

Overview:
- Fetch-side producer of the branch prediction that the branch control stage later checks.
- Holds the fetch PC and looks it up in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Drives the per-instruction prediction (pred_taken, pred_pc) down the pipeline.
- Consumes resolved-branch updates and flush/correction redirects coming back from the execute-side branch controller.

Parameters:
WordSize, 32, width of PC, targets and addresses.
Entries, 16, BTB entry count; power of two, 2..256.
ResetPC, 0, fetch PC loaded on reset; word aligned.

Ports:
clk  input  1  clock, rising edge.
rstn  input  1  asynchronous active-low reset.
stall  input  1  hold fetch PC (front end not accepting).
redirect  input  1  flush/correction from branch control; load redirect_pc.
redirect_pc  input  WordSize  corrected next PC.
upd_valid  input  1  resolved conditional branch update strobe.
upd_pc  input  WordSize  PC of resolved branch.
upd_taken  input  1  actual outcome.
upd_target  input  WordSize  actual taken target.
fetch_pc  output  WordSize  current fetch PC (registered).
pred_taken  output  1  prediction for instruction at fetch_pc.
pred_pc  output  WordSize  predicted next PC for fetch_pc.

Behaviour:
- Address fields, with IW = log2(Entries):
  - index = pc[IW+1:2]
  - tag = pc[WordSize-1:IW+2]
  - pc[1:0] ignored everywhere.
- Entry contents: valid, tag, target[WordSize-1:0], ctr[1:0].
  - Counter states: 0 SNT, 1 WNT, 2 WT, 3 ST.
- Reset, asynchronous on rstn low:
  - fetch_pc = ResetPC.
  - All valid = 0, all ctr = 0, targets/tags = 0.
  - Hence pred_taken = 0 and pred_pc = ResetPC+4 while in reset.
- Lookup, combinational on fetch_pc:
  - hit = valid[index] && tag matches.
  - pred_taken = hit && ctr[1].
  - pred_pc = pred_taken ? target : fetch_pc+4.
  - PC+4 wraps modulo 2^WordSize.
- Next PC on each rising edge, priority order:
  1. redirect = 1: fetch_pc <= redirect_pc. Applies even when stall = 1.
  2. stall = 1: fetch_pc holds.
  3. Otherwise: fetch_pc <= pred_pc.
- Update, on rising edge when upd_valid = 1; index and tag taken from upd_pc:
  - Hit, upd_taken = 1: ctr <= min(ctr+1, 3); target <= upd_target.
  - Hit, upd_taken = 0: ctr <= max(ctr-1, 0); target unchanged; entry stays valid.
  - Miss, upd_taken = 1: allocate, overwriting any occupant: valid = 1, tag, target = upd_target, ctr = 2 (WT).
  - Miss, upd_taken = 0: no change.
- Updates are independent of stall and redirect; an update in the same cycle as a redirect is applied.
- Update and lookup to the same index in the same cycle: lookup uses pre-update contents; the new contents are visible from the next cycle.
- Latency:
  - Prediction is available in the same cycle as fetch_pc (zero-cycle lookup).
  - A redirect takes effect on fetch_pc one cycle later.
  - A BTB update is visible to lookup one cycle later.
- Reset asserted mid-operation: all state clears immediately; the first PC after deassertion is ResetPC.
- No other state machine: the BTB and the PC register are the only state.

Test Plan:
- Reset then release with stall = 0, no updates, ResetPC = 0x100 -> fetch_pc = 0x100, 0x104, 0x108 on consecutive cycles; pred_taken = 0 throughout.
- Update upd_pc = 0x108, taken, target 0x200; then redirect to 0x100 -> fetch_pc sequence 0x100, 0x104, 0x108 (pred_taken = 1, pred_pc = 0x200), 0x200.
- Two not-taken updates at 0x108 after allocation -> ctr goes 2 → 1 → 0; pred_taken = 0 at 0x108; a further not-taken update leaves ctr at 0. Three taken updates -> ctr saturates at 3.
- Aliasing, Entries = 16: allocate 0x108; then a taken update at 0x148 (same index, different tag) -> lookup at 0x108 misses (pred_pc = 0x10C); lookup at 0x148 hits with the new target.
- stall = 1 and redirect = 1 to 0x400 in the same cycle -> fetch_pc = 0x400 next cycle; stall alone holds 0x400.
- Same-cycle update (taken, new target 0x300) and lookup at fetch_pc = 0x108 with old target 0x200 -> pred_pc = 0x200 this cycle, 0x300 the next time 0x108 is fetched; fetch_pc = 0xFFFFFFFC with a miss -> next fetch_pc = 0x0.
